cordic_bcd_display: RTL and testbench



---
 rtl/cordic_pkg.sv | 35 +++
 rtl/seg7_decode.sv | 26 ++
 rtl/cordic_bcd_display.sv | 140 ++++++++++++++
 tb/tb_cordic_bcd_display.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC BCD display stage: defaults,
// FSM encoding, 7-segment table and the per-digit double-dabble adjust.
package cordic_pkg;

  localparam int WIDTH_DEF  = 16;
  localparam int DIGITS_DEF = 5;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low gfedcba patterns, digit 0 in the least-significant slot.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0010000, // 9
    7'b0000000, // 8
    7'b1111000, // 7
    7'b0000010, // 6
    7'b0010010, // 5
    7'b0011001, // 4
    7'b0110000, // 3
    7'b0100100, // 2
    7'b1111001, // 1
    7'b1000000  // 0
  };

  // Double-dabble correction applied to each digit before the shift.
  function automatic logic [3:0] dd_step(input logic [3:0] digit);
    return (digit >= 4'd5) ? digit + 4'd3 : digit;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment decoder; non-decimal codes blank.
module seg7_decode
  import cordic_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_TABLE[0];
      4'd1: seg = SEG_TABLE[1];
      4'd2: seg = SEG_TABLE[2];
      4'd3: seg = SEG_TABLE[3];
      4'd4: seg = SEG_TABLE[4];
      4'd5: seg = SEG_TABLE[5];
      4'd6: seg = SEG_TABLE[6];
      4'd7: seg = SEG_TABLE[7];
      4'd8: seg = SEG_TABLE[8];
      4'd9: seg = SEG_TABLE[9];
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/cordic_bcd_display.sv
// Serial double-dabble conversion of a signed x/y pair to sign + BCD and six
// 7-segment digits. Optional leading-zero blanking via LEADING_ZERO_BLANK_EN.
module cordic_bcd_display
  import cordic_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      xin,
  input  logic [WIDTH-1:0]      yin,
  output logic                  out_valid,
  output logic                  x_neg,
  output logic [4*DIGITS-1:0]   x_bcd,
  output logic                  y_neg,
  output logic [4*DIGITS-1:0]   y_bcd,
  output logic [6:0]            hex0,
  output logic [6:0]            hex1,
  output logic [6:0]            hex2,
  output logic [6:0]            hex3,
  output logic [6:0]            hex4,
  output logic [6:0]            hex5
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  state_t          state;
  logic [WIDTH-1:0] x_mag, y_mag;
  logic [BW-1:0]   x_scr, y_scr;
  logic [BW-1:0]   x_adj, y_adj;
  logic            x_sign, y_sign;
  logic [CW-1:0]   count;

  logic [5:0][3:0] dig;
  logic [5:0][6:0] seg_raw;
  logic [5:0][6:0] seg_show;

  assign in_ready = (state == IDLE);

  always_comb begin
    x_adj = x_scr;
    y_adj = y_scr;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      x_adj[4*i +: 4] = dd_step(x_scr[4*i +: 4]);
      y_adj[4*i +: 4] = dd_step(y_scr[4*i +: 4]);
    end
  end

  // Displays show the low three digits; y occupies the upper group.
  assign dig[0] = x_scr[3:0];
  assign dig[1] = x_scr[7:4];
  assign dig[2] = x_scr[11:8];
  assign dig[3] = y_scr[3:0];
  assign dig[4] = y_scr[7:4];
  assign dig[5] = y_scr[11:8];

  for (genvar g = 0; g < 6; g++) begin : g_seg
    seg7_decode u_seg (
      .bcd (dig[g]),
      .seg (seg_raw[g])
    );
  end

  always_comb begin
    seg_show = seg_raw;
`ifdef LEADING_ZERO_BLANK_EN
    if (dig[2] == 4'd0)                     seg_show[2] = SEG_BLANK;
    if (dig[2] == 4'd0 && dig[1] == 4'd0)   seg_show[1] = SEG_BLANK;
    if (dig[5] == 4'd0)                     seg_show[5] = SEG_BLANK;
    if (dig[5] == 4'd0 && dig[4] == 4'd0)   seg_show[4] = SEG_BLANK;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      x_neg     <= 1'b0;
      y_neg     <= 1'b0;
      x_bcd     <= '0;
      y_bcd     <= '0;
      hex0      <= SEG_BLANK;
      hex1      <= SEG_BLANK;
      hex2      <= SEG_BLANK;
      hex3      <= SEG_BLANK;
      hex4      <= SEG_BLANK;
      hex5      <= SEG_BLANK;
      x_mag     <= '0;
      y_mag     <= '0;
      x_scr     <= '0;
      y_scr     <= '0;
      x_sign    <= 1'b0;
      y_sign    <= 1'b0;
      count     <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_sign <= xin[WIDTH-1];
            y_sign <= yin[WIDTH-1];
            // Two's-complement negate; the most negative value maps to 2^(WIDTH-1).
            x_mag  <= xin[WIDTH-1] ? -xin : xin;
            y_mag  <= yin[WIDTH-1] ? -yin : yin;
            x_scr  <= '0;
            y_scr  <= '0;
            count  <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          {x_scr, x_mag} <= {x_adj, x_mag} << 1;
          {y_scr, y_mag} <= {y_adj, y_mag} << 1;
          count          <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) state <= DONE;
        end
        DONE: begin
          x_bcd     <= x_scr;
          y_bcd     <= y_scr;
          x_neg     <= x_sign;
          y_neg     <= y_sign;
          hex0      <= seg_show[0];
          hex1      <= seg_show[1];
          hex2      <= seg_show[2];
          hex3      <= seg_show[3];
          hex4      <= seg_show[4];
          hex5      <= seg_show[5];
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_bcd_display.sv
// Scoreboard bench for cordic_bcd_display: driver pushes expected results,
// a negedge monitor pops and compares on every out_valid.
module tb_cordic_bcd_display;

  localparam int W = 16;
  localparam int D = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  xin, yin;
  logic          out_valid;
  logic          x_neg, y_neg;
  logic [4*D-1:0] x_bcd, y_bcd;
  logic [6:0]    hex0, hex1, hex2, hex3, hex4, hex5;

  always #5 clk = ~clk;

  cordic_bcd_display #(.WIDTH(W), .DIGITS(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .xin       (xin),
    .yin       (yin),
    .out_valid (out_valid),
    .x_neg     (x_neg),
    .x_bcd     (x_bcd),
    .y_neg     (y_neg),
    .y_bcd     (y_bcd),
    .hex0      (hex0),
    .hex1      (hex1),
    .hex2      (hex2),
    .hex3      (hex3),
    .hex4      (hex4),
    .hex5      (hex5)
  );

  typedef struct {
    logic [19:0]     xb;
    logic [19:0]     yb;
    logic            xn;
    logic            yn;
    logic [5:0][6:0] h;
    int              edge_n;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [19:0] to_bcd(input int v);
    int a;
    logic [19:0] r;
    a = (v < 0) ? -v : v;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(a % 10);
      a = a / 10;
    end
    return r;
  endfunction

  function automatic exp_t mk(input logic [19:0] xb, input logic xn,
                              input logic [19:0] yb, input logic yn);
    exp_t e;
    e.xb = xb; e.xn = xn; e.yb = yb; e.yn = yn; e.edge_n = 0;
    e.h[0] = seg_of(xb[3:0]);
    e.h[1] = seg_of(xb[7:4]);
    e.h[2] = seg_of(xb[11:8]);
    e.h[3] = seg_of(yb[3:0]);
    e.h[4] = seg_of(yb[7:4]);
    e.h[5] = seg_of(yb[11:8]);
`ifdef LEADING_ZERO_BLANK_EN
    if (xb[11:8] == 4'd0) e.h[2] = 7'b1111111;
    if (xb[11:4] == 8'd0) e.h[1] = 7'b1111111;
    if (yb[11:8] == 4'd0) e.h[5] = 7'b1111111;
    if (yb[11:4] == 8'd0) e.h[4] = 7'b1111111;
`endif
    return e;
  endfunction

  // Holds in_valid until accepted; returns the number of negedges spent waiting.
  task automatic send(input int x, input int y, input bit track,
                      input logic [19:0] xb, input logic xn,
                      input logic [19:0] yb, input logic yn,
                      output int waits);
    exp_t e;
    @(negedge clk);
    xin = x[W-1:0];
    yin = y[W-1:0];
    in_valid = 1'b1;
    waits = 0;
    while (!in_ready && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (track) begin
      e = mk(xb, xn, yb, yn);
      e.edge_n = cyc;
      sbq.push_back(e);
    end
  endtask

  task automatic drop_valid();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_x_bcd"},     32'(x_bcd),     32'd0);
    check({tag, "_y_bcd"},     32'(y_bcd),     32'd0);
    check({tag, "_x_neg"},     32'(x_neg),     32'd0);
    check({tag, "_y_neg"},     32'(y_neg),     32'd0);
    check({tag, "_hex_lo"},    32'({hex2, hex1, hex0}), 32'(21'h1fffff));
    check({tag, "_hex_hi"},    32'({hex5, hex4, hex3}), 32'(21'h1fffff));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (sbq.size() == 0) begin
          check("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          check("latency", 32'(cyc - 1), 32'(e.edge_n + 17));
          check("x_bcd", 32'(x_bcd), 32'(e.xb));
          check("y_bcd", 32'(y_bcd), 32'(e.yb));
          check("x_neg", 32'(x_neg), 32'(e.xn));
          check("y_neg", 32'(y_neg), 32'(e.yn));
          check("hex0", 32'(hex0), 32'(e.h[0]));
          check("hex1", 32'(hex1), 32'(e.h[1]));
          check("hex2", 32'(hex2), 32'(e.h[2]));
          check("hex3", 32'(hex3), 32'(e.h[3]));
          check("hex4", 32'(hex4), 32'(e.h[4]));
          check("hex5", 32'(hex5), 32'(e.h[5]));
        end
      end
    end
  end

  initial begin : stimulus
    int w;
    int x, y;
    int t;
    rst = 1'b1;
    in_valid = 1'b0;
    xin = '0;
    yin = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    send(174, 174, 1'b1, 20'h00174, 1'b0, 20'h00174, 1'b0, w);
    drop_valid();
    send(-32768, 32767, 1'b1, 20'h32768, 1'b1, 20'h32767, 1'b0, w);
    drop_valid();
    send(0, -1, 1'b1, 20'h00000, 1'b0, 20'h00001, 1'b1, w);
    drop_valid();

    // in_valid held through the busy period: second pair waits for IDLE.
    send(100, 200, 1'b1, 20'h00100, 1'b0, 20'h00200, 1'b0, w);
    send(555, 666, 1'b1, 20'h00555, 1'b0, 20'h00666, 1'b0, w);
    check("busy_wait", 32'(w), 32'd17);
    drop_valid();

    // Abort a conversion with reset on its 8th shift edge.
    send(1234, -4321, 1'b0, 20'h0, 1'b0, 20'h0, 1'b0, w);
    drop_valid();
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    send(42, 43, 1'b1, 20'h00042, 1'b0, 20'h00043, 1'b0, w);
    drop_valid();

    // Back-to-back stream with in_valid held high.
    for (int i = 0; i < 6; i++) begin
      x = i * 1111 - 3000;
      y = 9999 - i * 4321;
      send(x, y, 1'b1, to_bcd(x), x < 0, to_bcd(y), y < 0, w);
      if (i > 0) check("stream_gap", 32'(w), 32'd17);
    end
    drop_valid();

    t = 0;
    while (sbq.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sbq.size() > 0) check("drain", 32'(sbq.size()), 32'd0);
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
